// File: rtl/multicycle_control_unit_if.sv
// Bundles the fetch handshake, datapath selects, memory port and WB strobes of the control unit.
// master = control unit side, slave = fetch/datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int OP_WIDTH = 4
);
  logic                instr_valid;
  logic                instr_ready;
  logic [OP_WIDTH-1:0] opcode;
  logic                alu_zero;
  logic                mem_ack;
  logic                mem_req;
  logic                mem_we;
  logic [OP_WIDTH-1:0] alu_op;
  logic                alu_src_type;
  logic                is_reg_write;
  logic                pc_en;
  logic                pc_src;
  logic                err;

  modport master (
    input  instr_valid, opcode, alu_zero, mem_ack,
    output instr_ready, mem_req, mem_we, alu_op, alu_src_type,
           is_reg_write, pc_en, pc_src, err
  );

  modport slave (
    output instr_valid, opcode, alu_zero, mem_ack,
    input  instr_ready, mem_req, mem_we, alu_op, alu_src_type,
           is_reg_write, pc_en, pc_src, err
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer; 4 cycles per instruction, 4+wait for LOAD/STORE.
// Accepts an opcode only in FETCH; stalls in MEM until mem_ack or MEM_TIMEOUT cycles, then aborts.
module multicycle_control_unit #(
  parameter int OP_WIDTH    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  multicycle_control_unit_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OP_WIDTH-1:0] OP_LOAD  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_STORE = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(7);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

  state_t              state;
  logic [OP_WIDTH-1:0] op_q;
  logic                zero_q;
  logic [CNT_W-1:0]    tmo_cnt;

  function automatic logic legal(input logic [OP_WIDTH-1:0] op);
    return op < OP_WIDTH'(8);
  endfunction

  // Illegal opcodes run as a NOP with an all-ones ALU select.
  function automatic logic [OP_WIDTH-1:0] dec_alu_op(input logic [OP_WIDTH-1:0] op);
    if (!legal(op))
      return '1;
    else if (op < OP_WIDTH'(4))
      return op;
    else if (op == OP_BEQ)
      return OP_WIDTH'(1);
    else
      return '0;
  endfunction

  function automatic logic dec_src(input logic [OP_WIDTH-1:0] op);
    return (op >= OP_WIDTH'(4)) && (op <= OP_STORE);
  endfunction

  function automatic logic writes_reg(input logic [OP_WIDTH-1:0] op);
    return op <= OP_LOAD;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_FETCH;
      op_q             <= '0;
      zero_q           <= 1'b0;
      tmo_cnt          <= '0;
      bus.instr_ready  <= 1'b1;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.alu_op       <= '0;
      bus.alu_src_type <= 1'b0;
      bus.is_reg_write <= 1'b0;
      bus.pc_en        <= 1'b0;
      bus.pc_src       <= 1'b0;
      bus.err          <= 1'b0;
    end else begin
      bus.err          <= 1'b0;
      bus.is_reg_write <= 1'b0;
      bus.pc_en        <= 1'b0;
      bus.pc_src       <= 1'b0;
      case (state)
        S_FETCH: begin
          if (bus.instr_valid) begin
            state            <= S_DECODE;
            op_q             <= bus.opcode;
            bus.instr_ready  <= 1'b0;
            bus.alu_op       <= dec_alu_op(bus.opcode);
            bus.alu_src_type <= dec_src(bus.opcode);
            bus.err          <= !legal(bus.opcode);
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          zero_q <= bus.alu_zero;
          if (op_q == OP_LOAD || op_q == OP_STORE) begin
            state       <= S_MEM;
            tmo_cnt     <= '0;
            bus.mem_req <= 1'b1;
            bus.mem_we  <= (op_q == OP_STORE);
            bus.err     <= (MEM_TIMEOUT == 1);
          end else begin
            state            <= S_WB;
            bus.pc_en        <= 1'b1;
            bus.is_reg_write <= writes_reg(op_q);
            bus.pc_src       <= (op_q == OP_BEQ) && bus.alu_zero;
          end
        end
        S_MEM: begin
          // An ack in the final allowed cycle still completes the access normally.
          if (bus.mem_ack || (int'(tmo_cnt) + 1 == MEM_TIMEOUT)) begin
            state            <= S_WB;
            bus.mem_req      <= 1'b0;
            bus.mem_we       <= 1'b0;
            bus.pc_en        <= 1'b1;
            bus.is_reg_write <= bus.mem_ack && (op_q == OP_LOAD);
            bus.pc_src       <= (op_q == OP_BEQ) && zero_q;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            bus.err <= (int'(tmo_cnt) + 2 == MEM_TIMEOUT);
          end
        end
        S_WB: begin
          state            <= S_FETCH;
          bus.instr_ready  <= 1'b1;
          bus.alu_op       <= '0;
          bus.alu_src_type <= 1'b0;
        end
        default: begin
          state            <= S_FETCH;
          bus.instr_ready  <= 1'b1;
          bus.mem_req      <= 1'b0;
          bus.mem_we       <= 1'b0;
          bus.alu_op       <= '0;
          bus.alu_src_type <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed vector table, hand-written reset sequences,
// and random instructions checked cycle by cycle against a timeline model.
module tb_multicycle_control_unit;

  localparam int OPW = 4;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_control_unit_if #(.OP_WIDTH(OPW)) bus ();

  multicycle_control_unit #(.OP_WIDTH(OPW), .MEM_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       instr_ready;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] alu_op;
    logic       alu_src_type;
    logic       is_reg_write;
    logic       pc_en;
    logic       pc_src;
    logic       err;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    logic       zero;
    int         wait_cyc;
    bit         never;
    logic [3:0] alu;
    logic       src;
    logic       rw;
    logic       pcs;
    logic       ill;
  } vec_t;

  function automatic outs_t mk(input logic rdy, input logic req, input logic we,
                               input logic [3:0] alu, input logic src, input logic rw,
                               input logic pce, input logic pcs, input logic er);
    outs_t o;
    o.instr_ready  = rdy;
    o.mem_req      = req;
    o.mem_we       = we;
    o.alu_op       = alu;
    o.alu_src_type = src;
    o.is_reg_write = rw;
    o.pc_en        = pce;
    o.pc_src       = pcs;
    o.err          = er;
    return o;
  endfunction

  function automatic outs_t sample();
    return mk(bus.instr_ready, bus.mem_req, bus.mem_we, bus.alu_op, bus.alu_src_type,
              bus.is_reg_write, bus.pc_en, bus.pc_src, bus.err);
  endfunction

  task automatic check(input string name, input outs_t exp);
    outs_t g;
    g = sample();
    vectors++;
    if (g !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b (rdy,req,we,alu[4],src,rw,pce,pcs,err)",
               name, $time, g, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH back to FETCH; expected per-cycle outputs follow the timing rules.
  task automatic run_instr(input logic [3:0] op, input logic zero, input int wait_cyc,
                           input bit never, input int gap, input logic [3:0] e_alu,
                           input logic e_src, input logic e_rw, input logic e_pcs,
                           input logic e_ill, input bit hold_valid);
    bit is_mem;
    int n;
    is_mem = (op == 4'd5) || (op == 4'd6);
    for (int g = 0; g < gap; g++) begin
      check("fetch_idle", mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0));
      bus.instr_valid = 1'b0;
      bus.opcode      = 4'($urandom);
      bus.mem_ack     = 1'($urandom);
      step();
    end
    check("fetch", mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    bus.instr_valid = 1'b1;
    bus.opcode      = op;
    bus.mem_ack     = 1'($urandom);
    step();
    bus.instr_valid = hold_valid ? 1'b1 : 1'($urandom);
    bus.opcode      = 4'($urandom);
    check("decode", mk(0, 0, 0, e_alu, e_src, 0, 0, 0, e_ill));
    bus.mem_ack = 1'($urandom);
    step();
    check("exec", mk(0, 0, 0, e_alu, e_src, 0, 0, 0, 0));
    bus.alu_zero = zero;
    step();
    bus.alu_zero = 1'($urandom);
    if (is_mem) begin
      n = never ? TMO : wait_cyc + 1;
      for (int k = 1; k <= n; k++) begin
        check("mem", mk(0, 1, op == 4'd6, e_alu, e_src, 0, 0, 0, k == TMO));
        bus.mem_ack = !never && (k == n);
        step();
      end
    end
    check("wb", mk(0, 0, 0, e_alu, e_src, e_rw, 1, e_pcs, 0));
    bus.mem_ack     = 1'($urandom);
    bus.instr_valid = hold_valid ? 1'b1 : 1'($urandom);
    step();
  endtask

  vec_t tab[12];

  logic [3:0] alu_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd1};
  bit         src_tab [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
  bit         rw_tab  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    logic [3:0] op;
    logic       zero, e_src, e_rw, e_pcs, e_ill;
    logic [3:0] e_alu;
    int         w, gap;
    bit         never;

    tab[0]  = '{4'd0,  1'b0, 0,  1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0};
    tab[1]  = '{4'd4,  1'b1, 0,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tab[2]  = '{4'd7,  1'b1, 0,  1'b0, 4'd1,  1'b0, 1'b0, 1'b1, 1'b0};
    tab[3]  = '{4'd7,  1'b0, 0,  1'b0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{4'd5,  1'b0, 2,  1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{4'd6,  1'b1, 0,  1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{4'd5,  1'b0, 0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    tab[7]  = '{4'd9,  1'b1, 0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1};
    tab[8]  = '{4'd3,  1'b1, 0,  1'b0, 4'd3,  1'b0, 1'b1, 1'b0, 1'b0};
    tab[9]  = '{4'd5,  1'b0, 14, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0, 1'b0};
    tab[10] = '{4'd6,  1'b0, 0,  1'b1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0};
    tab[11] = '{4'd15, 1'b0, 0,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.alu_zero    = 1'b0;
    bus.mem_ack     = 1'b0;
    step();
    step();
    check("reset", mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Back-to-back with instr_valid held high: each handshake lands on the FETCH cycle after WB.
    foreach (tab[i])
      run_instr(tab[i].op, tab[i].zero, tab[i].wait_cyc, tab[i].never, 0,
                tab[i].alu, tab[i].src, tab[i].rw, tab[i].pcs, tab[i].ill, 1'b1);

    // Reset while waiting in MEM: outputs fall back to FETCH values before the next edge.
    check("pre_load", mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'd5;
    step();
    bus.instr_valid = 1'b0;
    bus.mem_ack     = 1'b0;
    step();
    step();
    check("mid_mem", mk(0, 1, 0, 4'd0, 1, 0, 0, 0, 0));
    step();
    #2 rst_n = 1'b0;
    #1 check("async_rst", mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0));
    step();
    rst_n       = 1'b1;
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_quiet", mk(1, 0, 0, 4'd0, 0, 0, 0, 0, 0));
      step();
    end
    bus.mem_ack = 1'b0;
    run_instr(4'd6, 1'b0, 1, 1'b0, 0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random instructions against the opcode table and timeline model.
    for (int t = 0; t < 200; t++) begin
      op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 7));
      zero  = 1'($urandom);
      never = ($urandom_range(0, 9) == 0);
      w     = ($urandom_range(0, 4) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 3);
      gap   = $urandom_range(0, 2);
      if (op > 4'd7) begin
        e_alu = 4'hF;
        e_src = 1'b0;
        e_rw  = 1'b0;
        e_pcs = 1'b0;
        e_ill = 1'b1;
      end else begin
        e_alu = alu_tab[op[2:0]];
        e_src = src_tab[op[2:0]];
        e_rw  = rw_tab[op[2:0]] && !(op == 4'd5 && never);
        e_pcs = (op == 4'd7) && zero;
        e_ill = 1'b0;
      end
      run_instr(op, zero, w, never, gap, e_alu, e_src, e_rw, e_pcs, e_ill, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
